// File: rtl/if_prefetch_pkg.sv
// Shared types for the instruction-fetch prefetch buffer.
package if_prefetch_pkg;

    localparam int INST_W = 32;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [31:0]       next_adr;
    } fifo_ent_t;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch storage: power-of-two circular buffer with synchronous push/pop/clear.
// Clear wins over push and pop in the same cycle.
module if_prefetch_fifo
    import if_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_clear,
    input  fifo_ent_t              i_data,
    output fifo_ent_t              o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);

    fifo_ent_t        r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_wr    = i_push & ~i_clear;
    assign w_rd    = i_pop & ~o_empty & ~i_clear;
    assign o_head  = r_mem[r_rp];
    assign o_count = r_count;
    assign o_full  = (r_count == DEPTH[AW:0]);
    assign o_empty = (r_count == '0);

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= i_data;
    end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch front end: issues up to two outstanding word fetches,
// buffers returned instructions, and flushes/drains on redirect.
// Build option: IF_PREFETCH_BYPASS_EN forwards a response straight to the
// output when the buffer is empty, saving one cycle of latency.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [31:0]       redirect_adr,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [31:0]       out_next_adr
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] OCC_MAX = DEPTH[CW:0];

    state_e      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_rsp_pc;     // address of the next response we intend to keep
    logic [1:0]  r_outst;      // all in-flight requests, dropped ones included
    logic [1:0]  r_drop;

    logic          w_rsp;
    logic          w_keep;
    logic          w_acc;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic [1:0]    w_left;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_occ;
    fifo_ent_t     w_head;
    fifo_ent_t     w_wdata;

    // A response with nothing outstanding belongs to a pre-reset request.
    assign w_rsp   = imem_rvalid & (r_outst != 2'd0);
    assign w_keep  = w_rsp & (r_state == RUN) & ~redirect;
    assign w_left  = r_outst - {1'b0, w_rsp};
    assign w_occ   = {1'b0, w_count} + {{(CW-1){1'b0}}, r_outst};
    assign w_wdata = '{inst: imem_rdata, next_adr: r_rsp_pc + 32'd4};

    // Every in-flight request owns a buffer slot, so a response always fits.
    assign imem_req  = rst & (r_state == RUN) & ~redirect &
                       (r_outst != 2'd2) & (w_occ < OCC_MAX);
    assign imem_addr = r_fetch_pc;
    assign w_acc     = imem_req & imem_gnt;

`ifdef IF_PREFETCH_BYPASS_EN
    logic w_byp;
    assign w_byp        = w_empty & w_keep;
    assign out_valid    = (~w_empty & ~redirect) | w_byp;
    assign out_inst     = w_byp ? imem_rdata       : (w_empty ? '0 : w_head.inst);
    assign out_next_adr = w_byp ? w_wdata.next_adr : (w_empty ? '0 : w_head.next_adr);
    assign w_pop        = ~w_empty & ~redirect & out_ready;
    assign w_push       = w_keep & ~(w_byp & out_ready) & (~w_full | w_pop);
`else
    assign out_valid    = ~w_empty & ~redirect;
    assign out_inst     = w_empty ? '0 : w_head.inst;
    assign out_next_adr = w_empty ? '0 : w_head.next_adr;
    assign w_pop        = out_valid & out_ready;
    assign w_push       = w_keep & (~w_full | w_pop);
`endif

    if_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (redirect),
        .i_data  (w_wdata),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Fetch PC, in-flight tracking and the RUN/DRAIN discard state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RUN;
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_outst    <= 2'd0;
            r_drop     <= 2'd0;
        end else begin
            r_outst <= w_left + {1'b0, w_acc};
            if (redirect) begin
                r_fetch_pc <= redirect_adr;
                r_rsp_pc   <= redirect_adr;
                r_drop     <= w_left;
                r_state    <= (w_left != 2'd0) ? DRAIN : RUN;
            end else begin
                if (w_acc)  r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_keep) r_rsp_pc   <= r_rsp_pc + 32'd4;
                if ((r_state == DRAIN) && w_rsp) begin
                    r_drop <= r_drop - 2'd1;
                    if (r_drop == 2'd1) r_state <= RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: a queue-based reference model checks every cycle,
// and directed scenarios pin hand-computed addresses and instructions.
module tb_if_prefetch;
    import if_prefetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_adr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_next_adr;

    int n_cmp  = 0;
    int n_fail = 0;

    if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect     (redirect),
        .redirect_adr (redirect_adr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_inst     (out_inst),
        .out_next_adr (out_next_adr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory with programmable latency ----------------
    typedef struct { logic [31:0] a; int due; } mreq_t;
    mreq_t mq[$];
    int cyc   = 0;
    int m_lat = 1;

    task automatic step(input logic r_n, input logic rd, input logic [31:0] ra,
                        input logic rdy, input logic xr);
        @(negedge clk);
        cyc++;
        rst          = r_n;
        redirect     = rd;
        redirect_adr = ra;
        out_ready    = rdy;
        imem_gnt     = 1'b1;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = inst_of(mq[0].a);
            void'(mq.pop_front());
        end else begin
            imem_rvalid = xr;
            imem_rdata  = 32'hBAD0_BAD0;
        end
        #1;
        if (imem_req && imem_gnt) mq.push_back('{imem_addr, cyc + m_lat});
    endtask

    task automatic go(input logic rdy);
        step(1'b1, 1'b0, 32'h0, rdy, 1'b0);
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] a; bit drop; } infl_t;
    typedef struct { logic [31:0] inst; logic [31:0] nxt; } ent_t;
    infl_t       infl[$];
    ent_t        fq[$];
    logic [31:0] m_pc = RESET_PC;

    // Checks outputs mid-cycle, then advances the model past the coming edge.
    always begin
        bit          drain, e_req, rsp, keep, byp, e_valid, pop;
        logic [31:0] e_inst, e_nxt;
        infl_t       e;
        @(negedge clk);
        #2;
        if (!rst) begin
            chk("rst_req",  {31'b0, imem_req},  32'd0);
            chk("rst_vld",  {31'b0, out_valid}, 32'd0);
            chk("rst_inst", out_inst,           32'd0);
            chk("rst_nxt",  out_next_adr,       32'd0);
            infl.delete();
            fq.delete();
            m_pc = RESET_PC;
        end else begin
            drain = 0;
            foreach (infl[i]) if (infl[i].drop) drain = 1;
            e_req = !drain && !redirect && infl.size() < 2 &&
                    (fq.size() + infl.size() < DEPTH);
            rsp   = imem_rvalid && infl.size() > 0;
            keep  = rsp && !infl[0].drop && !redirect;
            byp   = 0;
`ifdef IF_PREFETCH_BYPASS_EN
            byp   = keep && fq.size() == 0;
`endif
            e_valid = (fq.size() != 0 && !redirect) || byp;
            e_inst  = 32'h0;
            e_nxt   = 32'h0;
            if (byp) begin
                e_inst = imem_rdata;
                e_nxt  = infl[0].a + 32'd4;
            end else if (fq.size() != 0) begin
                e_inst = fq[0].inst;
                e_nxt  = fq[0].nxt;
            end
            chk("m_req", {31'b0, imem_req}, {31'b0, e_req});
            if (e_req) chk("m_addr", imem_addr, m_pc);
            chk("m_vld", {31'b0, out_valid}, {31'b0, e_valid});
            if (e_valid) begin
                chk("m_inst", out_inst, e_inst);
                chk("m_nxt",  out_next_adr, e_nxt);
            end
            e = '{32'h0, 1'b0};
            if (rsp) e = infl.pop_front();
            pop = e_valid && out_ready;
            if (redirect) begin
                fq.delete();
                foreach (infl[i]) infl[i].drop = 1;
                m_pc = redirect_adr;
            end else if (byp) begin
                if (!pop) fq.push_back('{imem_rdata, e.a + 32'd4});
            end else begin
                if (pop) void'(fq.pop_front());
                if (keep) fq.push_back('{imem_rdata, e.a + 32'd4});
            end
            if (e_req && imem_gnt) begin
                infl.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1'b0; redirect = 1'b0; redirect_adr = 32'h0; out_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

        // Reset state
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("reset_req", {31'b0, imem_req}, 32'd0);
        chk("reset_inst", out_inst, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming after release; a stray rvalid with nothing outstanding is ignored
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("s_addr0", imem_addr, 32'h0);
        chk("s_req0", {31'b0, imem_req}, 32'd1);
        go(1'b1); chk("s_addr4", imem_addr, 32'h4);
        chk("s_vld1", {31'b0, out_valid}, 32'd0);
        go(1'b1); chk("s_addr8", imem_addr, 32'h8);
        chk("s_vld2", {31'b0, out_valid}, 32'd1);
        chk("s_nxt4", out_next_adr, 32'h4);
        chk("s_inst0", out_inst, inst_of(32'h0));
        go(1'b1); chk("s_addrC", imem_addr, 32'hC);
        chk("s_nxt8", out_next_adr, 32'h8);
        go(1'b1); chk("s_nxtC", out_next_adr, 32'hC);

        // Back-pressure: four slots reserved, then requests stop
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            go(1'b0);
            if (i == 3) chk("bp_addrC", imem_addr, 32'hC);
            if (i == 4) chk("bp_req_off", {31'b0, imem_req}, 32'd0);
        end
        chk("bp_req_end", {31'b0, imem_req}, 32'd0);
        chk("bp_head_inst", out_inst, inst_of(32'h0));
        chk("bp_head_nxt", out_next_adr, 32'h4);
        go(1'b1); go(1'b1);

        // Redirect with two outstanding (3-cycle memory)
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        m_lat = 3;
        go(1'b1); go(1'b1);
        step(1'b1, 1'b1, 32'h100, 1'b1, 1'b0);
        go(1'b1);
        go(1'b1);
        chk("rd_vld_drain", {31'b0, out_valid}, 32'd0);
        chk("rd_req_drain", {31'b0, imem_req}, 32'd0);
        m_lat = 1;
        go(1'b1); chk("rd_addr100", imem_addr, 32'h100);
        chk("rd_req100", {31'b0, imem_req}, 32'd1);
        go(1'b1); chk("rd_vld_wait", {31'b0, out_valid}, 32'd0);
        go(1'b1); chk("rd_vld_new", {31'b0, out_valid}, 32'd1);
        chk("rd_nxt104", out_next_adr, 32'h104);
        chk("rd_inst100", out_inst, inst_of(32'h100));

        // Redirect colliding with out_ready and a returning response
        m_lat = 2;
        go(1'b1);
        go(1'b0);
        step(1'b1, 1'b1, 32'h200, 1'b1, 1'b0);
        chk("col_vld", {31'b0, out_valid}, 32'd0);
        go(1'b1);
        chk("col_drop", {30'b0, dut.r_drop}, 32'd1);
        m_lat = 1;
        go(1'b1); chk("col_addr200", imem_addr, 32'h200);

        // Address wrap at the top of the space
        go(1'b1); go(1'b1);
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        go(1'b1); chk("wr_addr_top", imem_addr, 32'hFFFF_FFFC);
        go(1'b1); chk("wr_addr0", imem_addr, 32'h0);
        go(1'b1); chk("wr_nxt0", out_next_adr, 32'h0);
        chk("wr_inst", out_inst, inst_of(32'hFFFF_FFFC));

        // Reset in the middle of a drain
        m_lat = 3;
        go(1'b1); go(1'b1);
        step(1'b1, 1'b1, 32'h300, 1'b1, 1'b0);
        go(1'b1);
        chk("md_state", 32'(dut.r_state), 32'(DRAIN));
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("md_req", {31'b0, imem_req}, 32'd0);
        chk("md_vld", {31'b0, out_valid}, 32'd0);
        chk("md_nxt", out_next_adr, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        m_lat = 1;
        go(1'b1); chk("md_first", imem_addr, RESET_PC);
        chk("md_first_req", {31'b0, imem_req}, 32'd1);
        go(1'b1); go(1'b1);
        chk("md_nxt_first", out_next_adr, RESET_PC + 32'd4);
        go(1'b1); go(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
